// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
// One request per imem_req&&imem_gnt; the response returns on imem_rvalid at least one cycle later.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: PC, one-outstanding imem requests, if_id pipeline registers; grant-to-if_id is 2 cycles.
// data_hazard holds if_id and parks an arriving response in a 1-deep skid; pipe_flush bubbles and redirects.
module fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INS   = 32'h0000_0013,
    parameter logic [31:0] BUBBLE_PC = 32'hffff_ffff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_flush,
    input  logic [31:0] flush_pc,
    input  logic        data_hazard,
    fetch_if.master     imem,
    output logic [31:0] if_id__pc,
    output logic [31:0] if_id__ins,
    output logic        if_id__ins_misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DISCARD,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        misalign;
    } if_id_t;

    localparam if_id_t BUBBLE = '{pc: BUBBLE_PC, ins: NOP_INS, misalign: 1'b0};

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    if_id_t      if_id;
    if_id_t      skid;
    logic        skid_v;

    logic issue;
    logic grant;
    logic rsp;

    assign rsp   = (state == S_BUSY) && imem.imem_rvalid;
    assign issue = !pipe_flush && !data_hazard && !skid_v && (pc[1:0] == 2'b00)
                   && ((state == S_IDLE) || rsp);
    assign grant = issue && imem.imem_gnt;

    // Gate with rst_n so no request leaks out while reset is held.
    assign imem.imem_req  = issue && rst_n;
    assign imem.imem_addr = pc;

    assign if_id__pc           = if_id.pc;
    assign if_id__ins          = if_id.ins;
    assign if_id__ins_misalign = if_id.misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            if_id  <= BUBBLE;
            skid   <= BUBBLE;
            skid_v <= 1'b0;
        end else begin
            if (grant) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end

            if (pipe_flush) begin
                // Any still-outstanding response must be swallowed before fetching the new target.
                pc     <= flush_pc;
                if_id  <= BUBBLE;
                skid_v <= 1'b0;
                if (((state == S_BUSY) || (state == S_DISCARD)) && !imem.imem_rvalid)
                    state <= S_DISCARD;
                else
                    state <= S_IDLE;
            end else if (data_hazard) begin
                if (rsp) begin
                    skid   <= '{pc: req_pc, ins: imem.imem_rdata, misalign: 1'b0};
                    skid_v <= 1'b1;
                    state  <= S_IDLE;
                end else if ((state == S_DISCARD) && imem.imem_rvalid) begin
                    state <= S_IDLE;
                end
            end else if (skid_v) begin
                if_id  <= skid;
                skid_v <= 1'b0;
            end else if (rsp) begin
                if_id <= '{pc: req_pc, ins: imem.imem_rdata, misalign: 1'b0};
                state <= grant ? S_BUSY : S_IDLE;
            end else if ((state == S_IDLE) && (pc[1:0] != 2'b00)) begin
                if_id <= '{pc: pc, ins: NOP_INS, misalign: 1'b1};
                state <= S_HALT;
            end else begin
                if_id <= BUBBLE;
                if (grant)
                    state <= S_BUSY;
                else if ((state == S_DISCARD) && imem.imem_rvalid)
                    state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: memory model with variable latency plus a stream-level reference of
// expected request addresses and presented instructions (each instruction = pc ^ 32'hA5).
module tb_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INS   = 32'h0000_0013;
    localparam logic [31:0] BUBBLE_PC = 32'hffff_ffff;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_flush;
    logic [31:0] flush_pc;
    logic        data_hazard;
    logic [31:0] if_id__pc;
    logic [31:0] if_id__ins;
    logic        if_id__ins_misalign;

    fetch_if bus();

    fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INS  (NOP_INS),
        .BUBBLE_PC(BUBBLE_PC)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pipe_flush         (pipe_flush),
        .flush_pc           (flush_pc),
        .data_hazard        (data_hazard),
        .imem               (bus),
        .if_id__pc          (if_id__pc),
        .if_id__ins         (if_id__ins),
        .if_id__ins_misalign(if_id__ins_misalign)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // memory model: one pending response, delivered pend_cnt cycles from now
    logic        pend_v;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          force_lat;
    int          gnt_pct;

    // reference: next address that must be requested, next pc that must be presented
    logic [31:0] req_exp;
    logic [31:0] pres_exp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic hz, input logic fl, input logic [31:0] fpc);
        logic        rv;
        logic        granted;
        logic [31:0] gaddr;
        logic [31:0] pre_pc;
        logic [31:0] pre_ins;
        logic        pre_mis;
        logic        bubble;
        logic        mis;
        @(negedge clk);
        data_hazard     = hz;
        pipe_flush      = fl;
        flush_pc        = fpc;
        rv              = pend_v && (pend_cnt == 0);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? (pend_addr ^ 32'hA5) : $urandom;
        bus.imem_gnt    = (!pend_v || rv) && ($urandom_range(0, 99) < gnt_pct);
        #1;
        pre_pc  = if_id__pc;
        pre_ins = if_id__ins;
        pre_mis = if_id__ins_misalign;
        granted = bus.imem_req && bus.imem_gnt;
        gaddr   = bus.imem_addr;
        if (rst_n) begin
            if (hz || fl) check_eq("req_blocked", 32'(bus.imem_req), 32'd0);
            if (req_exp[1:0] != 2'b00) check_eq("req_misaligned", 32'(bus.imem_req), 32'd0);
            if (granted) check_eq("req_addr", gaddr, req_exp);
        end
        @(posedge clk);
        #1;
        if (granted) begin
            pend_v    = 1'b1;
            pend_addr = gaddr;
            pend_cnt  = (force_lat != 0) ? force_lat - 1 : int'($urandom_range(0, 2));
            req_exp   = req_exp + 32'd4;
        end else if (rv) begin
            pend_v = 1'b0;
        end else if (pend_v) begin
            pend_cnt--;
        end
        bubble = (if_id__pc == BUBBLE_PC) && (if_id__ins == NOP_INS) && !if_id__ins_misalign;
        if (!rst_n) begin
            check_eq("rst_pc", if_id__pc, BUBBLE_PC);
            check_eq("rst_ins", if_id__ins, NOP_INS);
        end else if (fl) begin
            check_eq("flush_pc", if_id__pc, BUBBLE_PC);
            check_eq("flush_ins", if_id__ins, NOP_INS);
            check_eq("flush_mis", 32'(if_id__ins_misalign), 32'd0);
            req_exp  = fpc;
            pres_exp = fpc;
        end else if (hz) begin
            check_eq("hold_pc", if_id__pc, pre_pc);
            check_eq("hold_ins", if_id__ins, pre_ins);
            check_eq("hold_mis", 32'(if_id__ins_misalign), 32'(pre_mis));
        end else if (!bubble) begin
            mis = (pres_exp[1:0] != 2'b00);
            check_eq("pres_pc", if_id__pc, pres_exp);
            check_eq("pres_ins", if_id__ins, mis ? NOP_INS : (pres_exp ^ 32'hA5));
            check_eq("pres_mis", 32'(if_id__ins_misalign), 32'(mis));
            pres_exp = pres_exp + 32'd4;
        end
    endtask

    task automatic wait_pres(input logic [31:0] target, input string tag);
        for (int i = 0; i < 20 && pres_exp != target; i++) step(1'b0, 1'b0, 32'd0);
        check_eq(tag, pres_exp, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pc"}, if_id__pc, BUBBLE_PC);
        check_eq({tag, "_ins"}, if_id__ins, NOP_INS);
        check_eq({tag, "_mis"}, 32'(if_id__ins_misalign), 32'd0);
        check_eq({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] r;
        logic        hz;
        logic        fl;
        logic [31:0] fpc;

        rst_n           = 1'b0;
        pipe_flush      = 1'b0;
        data_hazard     = 1'b0;
        flush_pc        = 32'd0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        pend_v          = 1'b0;
        pend_addr       = 32'd0;
        pend_cnt        = 0;
        force_lat       = 1;
        gnt_pct         = 100;
        req_exp         = RESET_PC;
        pres_exp        = RESET_PC;

        #12;
        check_reset_outputs("reset");
        check_eq("reset_addr", bus.imem_addr, RESET_PC);
        rst_n = 1'b1;

        // fill: bubble at first edge, then one instruction per cycle from pc 0
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 32'd0);
            check_eq("fill_pc", if_id__pc, (k == 1) ? BUBBLE_PC : 32'((k - 2) * 4));
            if (k > 1) check_eq("fill_ins", if_id__ins, 32'((k - 2) * 4) ^ 32'hA5);
        end

        // stall with a response in flight: buffered, then released in order
        p = pres_exp;
        check_eq("stall_start", p, 32'd28);
        repeat (3) step(1'b1, 1'b0, 32'd0);
        repeat (4) step(1'b0, 1'b0, 32'd0);
        check_eq("stall_release", pres_exp, p + 32'd12);

        // flush one cycle after a slow grant: stale response dropped
        force_lat = 3;
        step(1'b0, 1'b0, 32'd0);
        force_lat = 1;
        step(1'b0, 1'b1, 32'h200);
        wait_pres(32'h204, "discard_resume");

        // misaligned target: one trap marker, no requests, until a new flush
        step(1'b0, 1'b1, 32'h102);
        repeat (6) step(1'b0, 1'b0, 32'd0);
        check_eq("halt_entry", pres_exp, 32'h106);
        check_eq("halt_noreq", req_exp, 32'h102);
        step(1'b0, 1'b1, 32'h300);
        wait_pres(32'h304, "halt_exit");

        // flush beats stall
        step(1'b1, 1'b1, 32'h340);
        wait_pres(32'h344, "flush_over_stall");

        // reset while a slow fetch is outstanding; its late response must be ignored
        force_lat = 3;
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        req_exp  = RESET_PC;
        pres_exp = RESET_PC;
        step(1'b0, 1'b0, 32'd0);
        rst_n     = 1'b1;
        force_lat = 1;
        wait_pres(32'h8, "refetch_after_reset");

        // random traffic
        force_lat = 0;
        gnt_pct   = 75;
        for (int i = 0; i < 1500; i++) begin
            r   = $urandom;
            hz  = ($urandom_range(0, 99) < 20);
            fl  = ($urandom_range(0, 99) < 5);
            fpc = ($urandom_range(0, 99) < 20) ? {22'd0, r[7:0], 2'b10} : {22'd0, r[7:0], 2'b00};
            step(hz, fl, fpc);
        end

        // drain: everything granted must eventually be presented exactly once
        force_lat = 1;
        gnt_pct   = 100;
        step(1'b0, 1'b1, 32'h400);
        repeat (6) step(1'b0, 1'b0, 32'd0);
        gnt_pct = 0;
        repeat (8) step(1'b0, 1'b0, 32'd0);
        check_eq("drain_complete", pres_exp, req_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
